// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data RAM.
// slave = arbiter side, master = requester/RAM side.
interface dmem_arbiter_if #(
    parameter int WORD_AW = 14,
    parameter int DATA_W  = 32
);
    logic               m0_req;
    logic               m0_we;
    logic [31:0]        m0_addr;
    logic [DATA_W-1:0]  m0_wdata;
    logic               m0_gnt;
    logic               m0_rvalid;
    logic [DATA_W-1:0]  m0_rdata;

    logic               m1_req;
    logic               m1_we;
    logic [31:0]        m1_addr;
    logic [DATA_W-1:0]  m1_wdata;
    logic               m1_gnt;
    logic               m1_rvalid;
    logic [DATA_W-1:0]  m1_rdata;

    logic               ram_we;
    logic [WORD_AW-1:0] ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a single-ported data RAM with one-cycle read latency.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module dmem_arbiter #(
    parameter int WORD_AW = 14,
    parameter int DATA_W  = 32
) (
    input  logic          clock,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t      state;
    logic        win;
    logic        pick1;
    logic        any_req;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

`ifdef DMEM_ARB_RR_EN
    logic last;  // port granted most recently; the other one wins a tie

    always_comb begin
        pick1 = 1'b0;
        if (bus.m1_req && (!bus.m0_req || !last))
            pick1 = 1'b1;
    end
`else
    always_comb begin
        pick1 = 1'b0;
        if (bus.m1_req && !bus.m0_req)
            pick1 = 1'b1;
    end
`endif

    assign any_req          = bus.m0_req | bus.m1_req;
    assign sel_addr         = pick1 ? bus.m1_addr : bus.m0_addr;
    assign unused_addr_bits = ^{sel_addr[31:WORD_AW+2], sel_addr[1:0]};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            win           <= 1'b0;
            bus.m0_gnt    <= 1'b0;
            bus.m1_gnt    <= 1'b0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rdata  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
`ifdef DMEM_ARB_RR_EN
            last          <= 1'b1;
`endif
        end else begin
            bus.m0_gnt    <= 1'b0;
            bus.m1_gnt    <= 1'b0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.ram_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state         <= ACCESS;
                        win           <= pick1;
                        bus.m0_gnt    <= !pick1;
                        bus.m1_gnt    <= pick1;
                        bus.ram_we    <= pick1 ? bus.m1_we : bus.m0_we;
                        bus.ram_addr  <= sel_addr[WORD_AW+1:2];
                        bus.ram_wdata <= pick1 ? bus.m1_wdata : bus.m0_wdata;
`ifdef DMEM_ARB_RR_EN
                        last          <= pick1;
`endif
                    end
                end
                // ram_we still holds the latched direction during ACCESS
                ACCESS: state <= bus.ram_we ? IDLE : RDWAIT;
                RDWAIT: begin
                    state <= IDLE;
                    if (win) begin
                        bus.m1_rdata  <= bus.ram_rdata;
                        bus.m1_rvalid <= 1'b1;
                    end else begin
                        bus.m0_rdata  <= bus.ram_rdata;
                        bus.m0_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
